gf2_poly_reduce: RTL and testbench
==================================

Name: gf2_poly_reduce

Overview:
- Sequential GF(2^30) modular reduction stage that sits directly downstream of the 30x30 combinational Karatsuba multiplier.
- Takes the 59-bit carry-less product and reduces it modulo the field polynomial x^30 + POLY(x), giving a 30-bit field element.
- Processes one product bit per cycle; valid/ready handshakes on both sides.
- Area-lean alternative to a flat XOR reduction tree; fixed latency so the downstream scheduler can rely on it.

Parameters:
- N, 30, field degree; input width 2N-1, output width N.
- POLY, 30'h0000_0003, low N coefficients of the field polynomial (implicit x^N term; default is x^30 + x + 1).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  prod is valid.
- in_ready  output  1  block can accept a product.
- prod  input  2N-1  unreduced product; bit i is the coefficient of x^i.
- out_valid  output  1  res holds a completed reduction.
- out_ready  input  1  consumer accepts res.
- res  output  N  reduced result, prod mod (x^N + POLY).

Behaviour:
- State: FSM {IDLE, RUN, DONE}, 2N-1-bit accumulator acc, down-counter cnt of ceil(log2(N)) bits.
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, acc=0, cnt=0.
  - Outputs: in_ready=1, out_valid=0, res=0.
  - Reset wins over every other event, including a handshake in the same cycle, and aborts a RUN or DONE in progress. No partial result is ever presented.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1: acc<=prod, cnt<=N-2, go to RUN.
- RUN:
  - in_ready=0, out_valid=0. in_valid is ignored and prod is not sampled.
  - Each cycle, let k=cnt. If acc[N+k]=1, acc <= acc ^ ({1'b1,POLY} << k); otherwise acc is unchanged.
  - If k==0, go to DONE; else cnt<=k-1.
  - Bits are processed from x^(2N-2) down to x^N: exactly N-1 cycles (29 at default), independent of data. No early exit.
  - Cascaded feedback into lower bits is absorbed automatically because lower bits are processed later, so any POLY of degree < N is correct.
- DONE:
  - out_valid=1, res=acc[N-1:0], in_ready=0.
  - res and out_valid stay stable while out_ready=0 (unbounded backpressure).
  - On out_ready=1: go to IDLE; out_valid falls and in_ready rises the next cycle.
- res is 0 whenever out_valid=0 (driven from acc only in DONE).
- Latency: accept edge E. out_valid rises after edge E+N-1 (E+29 at default). Minimum initiation interval is N+1 cycles with out_ready tied high.
- Boundary cases:
  - prod with bits [2N-2:N] all zero: passes through unchanged, still with full latency.
  - prod=0: res=0.
  - in_valid held high across DONE->IDLE: the next product is accepted on the first IDLE cycle, not in DONE.
  - X on prod while in_ready=0: must not propagate.

Test Plan:
1. Reset, then prod=59'h0 -> out_valid exactly 29 cycles after accept, res=30'h0000_0000, in_ready low throughout RUN/DONE.
2. prod=1<<30 -> res=30'h0000_0003; prod=1<<58 -> res=30'h3000_0000; prod=1<<57 -> res=30'h1800_0000.
3. prod=(1<<58)|(1<<30)|30'h3FFF_FFFF -> res=30'h3000_0003 ^ 30'h3FFF_FFFF = 30'h0FFF_FFFC; prod=30'h3FFF_FFFF (no high bits) -> res=30'h3FFF_FFFF.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> res/out_valid stable, in_ready=0. Raise out_ready -> next cycle IDLE. Back-to-back with in_valid held high -> second accept on that IDLE cycle.
5. Assert rst at RUN cycle 12 with in_valid=1 -> next cycle IDLE, out_valid=0, res=0, no result emitted. A fresh prod=1<<30 then yields 30'h3.
6. Random regression: 10k products from the Karatsuba multiplier on random A,B -> res matches a reference model of A*B mod x^30+x+1. Repeat with POLY=30'h2000_0001 to exercise cascaded feedback.

Source files
------------

// File: rtl/gf2_poly_reduce.sv
// gf2_poly_reduce: bit-serial reduction of a 2N-1-bit carry-less product modulo x^N + POLY
module gf2_poly_reduce #(
  parameter int N = 30,
  parameter logic [N-1:0] POLY = 30'h0000_0003
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-2:0]   prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     res
);
  localparam int W = 2*N-1;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] acc, acc_n, red, sh;
  logic [CW-1:0] cnt, cnt_n;
  // reduction polynomial aligned so its implicit x^N term lands on bit N+cnt
  assign red = W'({1'b1, POLY}) << cnt;
  assign sh = acc >> cnt;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign res = out_valid ? acc[N-1:0] : '0;
  // next state: load in IDLE, clear one high bit per RUN cycle from the top down, hold in DONE
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    case (state)
      IDLE: if (in_valid) begin
        acc_n = prod;
        cnt_n = CW'(N-2);
        state_n = RUN;
      end
      RUN: begin
        acc_n = sh[N] ? acc ^ red : acc;
        cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
        state_n = cnt == '0 ? DONE : RUN;
      end
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // state register; reset aborts any reduction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_gf2_poly_reduce.sv
// tb_gf2_poly_reduce: table vectors, corner sequences and scoreboarded random products
module tb_gf2_poly_reduce;
  localparam logic [29:0] P0 = 30'h0000_0003;
  localparam logic [29:0] P1 = 30'h2000_0001;
  typedef struct {logic [58:0] p; logic [29:0] r;} vec_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, rnd_or = 0;
  logic [58:0] prod = '0;
  logic rdy0, rdy1, ov0, ov1;
  logic [29:0] res0, res1, exp0 = '0, exp1 = '0, hold;
  logic [29:0] q0[$], q1[$];
  vec_t tv[8];
  int n_cmp = 0, n_bad = 0, n, seen;

  gf2_poly_reduce #(.N(30), .POLY(P0)) u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .prod(prod), .out_valid(ov0), .out_ready(out_ready), .res(res0));
  gf2_poly_reduce #(.N(30), .POLY(P1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .prod(prod), .out_valid(ov1), .out_ready(out_ready), .res(res1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [29:0] xt(input logic [29:0] t, input logic [29:0] p);
    return t[29] ? ((t << 1) ^ p) : (t << 1);
  endfunction

  function automatic logic [29:0] ref_mod(input logic [58:0] v, input logic [29:0] p);
    logic [29:0] r = '0, t = 30'd1;
    for (int i = 0; i < 59; i++) begin
      if (v[i]) r ^= t;
      t = xt(t, p);
    end
    return r;
  endfunction

  function automatic logic [29:0] gf_mul(input logic [29:0] a, b, p);
    logic [29:0] r = '0;
    for (int i = 29; i >= 0; i--) begin
      r = xt(r, p);
      if (b[i]) r ^= a;
    end
    return r;
  endfunction

  function automatic logic [58:0] clmul(input logic [29:0] a, b);
    logic [58:0] r = '0;
    for (int i = 0; i < 30; i++) if (b[i]) r ^= 59'(a) << i;
    return r;
  endfunction

  // scoreboard: push on accept, pop and compare on output handshake; reset discards pending work
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (in_valid && rdy0) q0.push_back(exp0);
      if (in_valid && rdy1) q1.push_back(exp1);
      if (ov0 && out_ready) begin
        if (q0.size() == 0) chk("u0 spurious output", 1, 0);
        else chk("u0 res", res0, q0.pop_front());
      end
      if (ov1 && out_ready) begin
        if (q1.size() == 0) chk("u1 spurious output", 1, 0);
        else chk("u1 res", res1, q1.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (rnd_or) out_ready = $urandom_range(0, 3) != 0;
  endtask

  task automatic send(input logic [58:0] p, input logic [29:0] e0, input logic [29:0] e1);
    prod = p;
    exp0 = e0;
    exp1 = e1;
    in_valid = 1;
    for (int i = 0; i < 200 && !rdy0; i++) tick();
    if (!rdy0) chk("accept timeout", rdy0, 1);
    tick();
    in_valid = 0;
    prod = 'x;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q0.size() + q1.size()) != 0; i++) tick();
    chk("drain", q0.size() + q1.size(), 0);
  endtask

  initial begin
    tv[0] = '{59'd1 << 30, 30'h0000_0003};
    tv[1] = '{59'd1 << 58, 30'h3000_0000};
    tv[2] = '{59'd1 << 57, 30'h1800_0000};
    tv[3] = '{(59'd1 << 58) | (59'd1 << 30) | 59'h3FFF_FFFF, 30'h0FFF_FFFC};
    tv[4] = '{59'h3FFF_FFFF, 30'h3FFF_FFFF};
    tv[5] = '{59'd1 << 31, 30'h0000_0006};
    tv[6] = '{59'd1 << 44, 30'h0000_C000};
    tv[7] = '{59'h0, 30'h0};
    tick();
    tick();
    chk("reset in_ready", rdy0, 1);
    chk("reset out_valid", ov0, 0);
    chk("reset res", res0, 0);
    rst = 0;
    tick();
    // zero product: full latency, in_ready low and res zero throughout RUN
    send(59'h0, 30'h0, 30'h0);
    n = 0;
    while (!ov0 && n < 40) begin
      chk("run in_ready", rdy0, 0);
      chk("run res", res0, 0);
      tick();
      n++;
    end
    chk("latency", n, 29);
    drain();
    tick();
    foreach (tv[i]) begin
      send(tv[i].p, tv[i].r, ref_mod(tv[i].p, P1));
      drain();
    end
    // backpressure in DONE, then back-to-back accept on the IDLE cycle
    out_ready = 0;
    send(59'd1 << 30, 30'h3, ref_mod(59'd1 << 30, P1));
    for (int i = 0; i < 40 && !ov0; i++) tick();
    hold = res0;
    chk("stall res", hold, 30'h3);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall res stable", res0, hold);
      chk("stall out_valid", ov0, 1);
      chk("stall in_ready", rdy0, 0);
    end
    prod = 59'd1 << 58;
    exp0 = 30'h3000_0000;
    exp1 = ref_mod(59'd1 << 58, P1);
    in_valid = 1;
    out_ready = 1;
    tick();
    chk("b2b idle in_ready", rdy0, 1);
    chk("b2b idle out_valid", ov0, 0);
    chk("b2b idle res", res0, 0);
    tick();
    chk("b2b accepted", rdy0, 0);
    in_valid = 0;
    prod = 'x;
    drain();
    // reset mid-RUN with in_valid high: abort, no result
    send(59'd1 << 58, 30'h3000_0000, ref_mod(59'd1 << 58, P1));
    for (int i = 0; i < 11; i++) tick();
    rst = 1;
    in_valid = 1;
    prod = 59'd1 << 30;
    tick();
    rst = 0;
    in_valid = 0;
    prod = 'x;
    chk("abort in_ready", rdy0, 1);
    chk("abort out_valid", ov0, 0);
    chk("abort res", res0, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ov0 || ov1) seen++;
      tick();
    end
    chk("abort no output", seen, 0);
    send(59'd1 << 30, 30'h3, ref_mod(59'd1 << 30, P1));
    drain();
    // random products with random backpressure on both polynomials
    rnd_or = 1;
    for (int i = 0; i < 600; i++) begin
      logic [29:0] a, b;
      a = 30'($urandom);
      b = 30'($urandom);
      send(clmul(a, b), gf_mul(a, b, P0), gf_mul(a, b, P1));
    end
    rnd_or = 0;
    out_ready = 1;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
